uart_rx_fifo_wb: RTL and testbench
==================================

Name: uart_rx_fifo_wb

Overview:
- Wishbone slave that buffers bytes received by the UART, so the core can drain them in bursts instead of taking one interrupt per byte.
- Sits directly downstream of uart_wb: consumes its rx_byte_o / rx_irq_o pulse pair, stores bytes in a circular FIFO, and exposes DATA/STATUS/CTRL registers on the data bus.
- Raises a level interrupt (fast_irq line) when the fill level reaches a programmable threshold.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (16 entries).
- BASE_ADR, 32'h0000_8018, base address; registers at +0x0, +0x4, +0x8.

Ports:
- clk_i  input  1  system clock.
- reset_i  input  1  asynchronous, active-low reset.
- wb_cyc_i  input  1  Wishbone cycle.
- wb_stb_i  input  1  Wishbone strobe, already gated by the interconnect address decode.
- wb_we_i  input  1  write enable.
- wb_adr_i  input  32  byte address; only bits [3:2] are decoded.
- wb_dat_i  input  32  write data.
- wb_sel_i  input  4  byte selects; ignored, all accesses are treated as full-word.
- wb_stall_o  output  1  tied 0.
- wb_ack_o  output  1  transfer acknowledge.
- wb_dat_o  output  32  read data.
- wb_err_o  output  1  bus error.
- rx_valid_i  input  1  one-cycle pulse; new byte available (from uart rx_irq_o).
- rx_byte_i  input  8  received byte, valid when rx_valid_i = 1.
- irq_o  output  1  level interrupt to the core.

Behaviour:
- Reset (reset_i = 0, asynchronous) forces:
  - wb_ack_o = 0, wb_err_o = 0, wb_dat_o = 0, irq_o = 0.
  - FIFO pointers = 0, count = 0, overflow = 0.
  - CTRL.irq_en = 0, CTRL.thresh = 1.
- FIFO: DEPTH = 2^DEPTH_LOG2 entries of 8 bits. Read/write pointers are DEPTH_LOG2 bits wide and wrap modulo DEPTH. count is DEPTH_LOG2+1 bits, range 0..DEPTH.
- Push: on rx_valid_i = 1.
  - If not full, write rx_byte_i at the write pointer; wrptr+1, count+1.
  - If full (count = DEPTH), drop the byte and set sticky overflow = 1; FIFO contents unchanged.
- Bus accept: a transfer is accepted in any cycle with wb_cyc_i & wb_stb_i = 1. There is no stall, so a new transfer can be accepted every cycle.
- Response timing:
  - wb_ack_o (or wb_err_o) is registered and asserted exactly 1 cycle after accept, for 1 cycle.
  - wb_dat_o is valid in that same cycle.
  - With no accept, wb_ack_o = wb_err_o = 0.
- Register map (offset = wb_adr_i[3:2]):
  - 0 DATA, read: if not empty, returns {24'b0, head byte} and pops (rdptr+1, count-1) in the accept cycle. If empty, returns 32'h8000_0000 and does not pop. Writes are acked and ignored.
  - 1 STATUS, read-only: [DEPTH_LOG2:0] = count, [16] = empty, [17] = full, [18] = overflow. Any write is acked and clears overflow; wb_dat_i is ignored.
  - 2 CTRL, read/write:
    - [0] irq_en.
    - [DEPTH_LOG2+8:8] thresh. A written value of 0 is stored as 1; a value above DEPTH is stored as DEPTH.
    - [31] flush, write-1: resets pointers and count to 0, does not clear overflow, always reads 0.
  - 3 unmapped: wb_err_o = 1 instead of ack; wb_dat_o = 0; no side effects.
- Simultaneous push and pop in the same cycle:
  - Both take effect; count is unchanged.
  - When full, the pop frees a slot in the same cycle, so the push succeeds and overflow is not set.
  - When empty, the DATA read returns 32'h8000_0000 and the pushed byte is stored; count becomes 1.
- Simultaneous push and flush: flush wins; the byte is discarded, count = 0, overflow unaffected.
- Simultaneous push on a full FIFO and a STATUS write: the clear wins; overflow = 0.
- irq_o: registered, irq_o = irq_en & (count >= thresh), evaluated on next-state values. It deasserts the cycle after a pop brings count below thresh.
- Non-accept cycles: wb_dat_o holds its last value. Accepts while reset_i = 0 are ignored.

Test Plan:
- Reset, then read STATUS: ack after 1 cycle; dat = 32'h0001_0000 (empty); irq_o = 0.
- Push 0x41, 0x42, 0x43, then read DATA three times: returns 0x41, 0x42, 0x43 in order. A fourth read returns 32'h8000_0000; count stays 0.
- Push 17 bytes 0x00..0x10 (DEPTH = 16), then read STATUS: count = 16, full = 1, overflow = 1. Then write STATUS: overflow = 0. Drain 16 reads: 0x00..0x0F; 0x10 was dropped.
- Write CTRL = 32'h0000_0401 (irq_en, thresh = 4), then push 3 bytes: irq_o = 0. On the 4th push, irq_o = 1 on the following cycle. One DATA read drops irq_o to 0 one cycle later.
- Fill to 16, then issue a DATA read in the same cycle as rx_valid_i with byte 0x5A: read returns the oldest byte, count stays 16, overflow = 0, and 0x5A comes out last. Repeat the same-cycle push/read on an empty FIFO: read returns 32'h8000_0000 and count becomes 1.
- Pointer wrap and faults: run 40 alternating push/pop pairs; data stays in order across the pointer wrap. Access offset 0xC: wb_err_o = 1, no ack, no state change. Pulse reset_i low while the FIFO holds 5 bytes: count = 0, CTRL = thresh 1 / irq_en 0, no ack is issued for a transfer accepted in the cycle reset asserted.

Source files
------------

// File: rtl/uart_rx_fifo_wb.sv
// uart_rx_fifo_wb: Wishbone-readable receive FIFO placed behind uart_wb.
// It collects the rx_valid_i/rx_byte_i pulses into a circular buffer, exposes
// DATA/STATUS/CTRL registers, and raises a level interrupt once the fill
// level reaches a programmable threshold.
//
// Handshake semantics: a bus transfer is accepted in every cycle where
// wb_cyc_i & wb_stb_i is high (wb_stall_o is tied low, so the slave is
// always ready). Exactly one cycle later wb_ack_o (or wb_err_o for the
// unmapped offset) is high for one cycle, with wb_dat_o valid in that cycle.
// rx_valid_i is a one-cycle "valid" with no back-pressure: a byte that
// arrives while the FIFO is full is dropped and flagged in the sticky
// overflow bit.

module uart_rx_fifo_wb #(
    parameter int          DEPTH_LOG2 = 4,
    parameter logic [31:0] BASE_ADR   = 32'h0000_8018
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_stall_o,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_err_o,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_byte_i,
    output logic        irq_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_NONE   = 2'd3;

    localparam logic [31:0] EMPTY_WORD = 32'h8000_0000;

    // FIFO storage and state
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          irq_en;
    logic [CW-1:0] thresh;

    // next-state values
    logic [PW-1:0] wr_ptr_nxt;
    logic [PW-1:0] rd_ptr_nxt;
    logic [CW-1:0] count_nxt;
    logic          overflow_nxt;
    logic          irq_en_nxt;
    logic [CW-1:0] thresh_nxt;

    // decoded transfer and FIFO events
    logic          accept;
    logic [1:0]    reg_off;
    logic          empty;
    logic          full;
    logic          do_pop;
    logic          do_push;
    logic          do_flush;
    logic          ctrl_wr;
    logic          stat_wr;
    logic [CW-1:0] thresh_wr;
    logic [31:0]   status_word;
    logic [31:0]   ctrl_word;
    logic [31:0]   rdata;

    // Byte selects and address bits outside [3:2] carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{wb_sel_i, wb_adr_i, wb_dat_i, BASE_ADR};

    assign wb_stall_o = 1'b0;

    // Offsets are taken relative to BASE_ADR so that base+0x0 is DATA even
    // when the base itself has bits [3:2] set; only adr[3:2] participate.
    assign accept   = wb_cyc_i & wb_stb_i;
    assign reg_off  = wb_adr_i[3:2] - BASE_ADR[3:2];
    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign ctrl_wr  = accept & wb_we_i & (reg_off == REG_CTRL);
    assign stat_wr  = accept & wb_we_i & (reg_off == REG_STATUS);
    assign do_flush = ctrl_wr & wb_dat_i[31];
    assign do_pop   = accept & ~wb_we_i & (reg_off == REG_DATA) & ~empty;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign do_push  = rx_valid_i & ~do_flush & (~full | do_pop);
    assign thresh_wr = wb_dat_i[DEPTH_LOG2+8:8];

    // Pack the read-only status word and the readable part of CTRL.
    always_comb begin
        status_word         = '0;
        status_word[CW-1:0] = count;
        status_word[16]     = empty;
        status_word[17]     = full;
        status_word[18]     = overflow;
        ctrl_word           = '0;
        ctrl_word[0]        = irq_en;
        ctrl_word[CW+7:8]   = thresh;
    end

    // Read mux; writes and the unmapped offset return zero.
    always_comb begin
        rdata = '0;
        if (!wb_we_i) begin
            case (reg_off)
                REG_DATA:   rdata = empty ? EMPTY_WORD : {24'b0, mem[rd_ptr]};
                REG_STATUS: rdata = status_word;
                REG_CTRL:   rdata = ctrl_word;
                default:    rdata = '0;
            endcase
        end
    end

    // Next-state for pointers, count, overflow and control fields.
    always_comb begin
        wr_ptr_nxt   = wr_ptr;
        rd_ptr_nxt   = rd_ptr;
        count_nxt    = count;
        overflow_nxt = overflow;
        irq_en_nxt   = irq_en;
        thresh_nxt   = thresh;

        if (do_flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            count_nxt  = '0;
        end else begin
            if (do_push) wr_ptr_nxt = wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr_nxt = rd_ptr + PTR_ONE;
            count_nxt = count + CW'(do_push) - CW'(do_pop);
        end

        // A STATUS write beats a simultaneous drop; a flush never drops.
        if (stat_wr) begin
            overflow_nxt = 1'b0;
        end else if (rx_valid_i & full & ~do_pop & ~do_flush) begin
            overflow_nxt = 1'b1;
        end

        if (ctrl_wr) begin
            irq_en_nxt = wb_dat_i[0];
            if (thresh_wr == '0) begin
                thresh_nxt = CNT_ONE;
            end else if (thresh_wr > FULL_CNT) begin
                thresh_nxt = FULL_CNT;
            end else begin
                thresh_nxt = thresh_wr;
            end
        end
    end

    // FIFO byte storage; contents need no reset since count gates reads.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= rx_byte_i;
    end

    // FIFO state, control register and interrupt (from next-state values).
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            irq_en   <= 1'b0;
            thresh   <= CNT_ONE;
            irq_o    <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            count    <= count_nxt;
            overflow <= overflow_nxt;
            irq_en   <= irq_en_nxt;
            thresh   <= thresh_nxt;
            irq_o    <= irq_en_nxt & (count_nxt >= thresh_nxt);
        end
    end

    // Registered bus response, one cycle after accept; data holds otherwise.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= accept & (reg_off != REG_NONE);
            wb_err_o <= accept & (reg_off == REG_NONE);
            if (accept) wb_dat_o <= rdata;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo_wb.sv
// Testbench for uart_rx_fifo_wb: a table of single-cycle vectors followed by
// hand-written sequences for overflow, same-cycle push/pop, pointer wrap,
// the unmapped offset and an asynchronous reset pulse.

module tb_uart_rx_fifo_wb;

    // Base chosen with [3:2] = 0 so base+off*4 decodes as offset 'off'.
    localparam logic [31:0] BASE = 32'h0000_8000;

    // clock / reset block
    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [31:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [3:0]  wb_sel_i = 4'hF;
    logic        wb_stall_o;
    logic        wb_ack_o;
    logic [31:0] wb_dat_o;
    logic        wb_err_o;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  rx_byte_i = '0;
    logic        irq_o;

    always #5 clk_i = ~clk_i;

    uart_rx_fifo_wb #(
        .DEPTH_LOG2(4),
        .BASE_ADR  (BASE)
    ) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .wb_cyc_i  (wb_cyc_i),
        .wb_stb_i  (wb_stb_i),
        .wb_we_i   (wb_we_i),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_sel_i  (wb_sel_i),
        .wb_stall_o(wb_stall_o),
        .wb_ack_o  (wb_ack_o),
        .wb_dat_o  (wb_dat_o),
        .wb_err_o  (wb_err_o),
        .rx_valid_i(rx_valid_i),
        .rx_byte_i (rx_byte_i),
        .irq_o     (irq_o)
    );

    // scoreboard
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        string       name;
        logic        bus;
        logic        we;
        logic [1:0]  off;
        logic [31:0] wdat;
        logic        push;
        logic [7:0]  pb;
        logic        exp_ack;
        logic        exp_err;
        logic        exp_irq;
        logic        chk_dat;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input string name, input logic bus, input logic we,
                                    input logic [1:0] off, input logic [31:0] wdat,
                                    input logic push, input logic [7:0] pb,
                                    input logic ea, input logic ee, input logic ei,
                                    input logic cd, input logic [31:0] ed);
        vec_t v;
        v.name = name; v.bus = bus; v.we = we; v.off = off; v.wdat = wdat;
        v.push = push; v.pb = pb; v.exp_ack = ea; v.exp_err = ee; v.exp_irq = ei;
        v.chk_dat = cd; v.exp_dat = ed;
        vecs.push_back(v);
    endfunction

    // driver tasks: each call occupies exactly one clock cycle and returns
    // 1 time unit after the edge that registered the response.
    task automatic drive_cycle(input logic bus, input logic we, input logic [1:0] off,
                               input logic [31:0] wdat, input logic push, input logic [7:0] pb);
        wb_cyc_i   = bus;
        wb_stb_i   = bus;
        wb_we_i    = we;
        wb_adr_i   = BASE + {28'b0, off, 2'b00};
        wb_dat_i   = wdat;
        rx_valid_i = push;
        rx_byte_i  = pb;
        @(posedge clk_i);
        #1;
        wb_cyc_i   = 1'b0;
        wb_stb_i   = 1'b0;
        wb_we_i    = 1'b0;
        rx_valid_i = 1'b0;
    endtask

    task automatic read_expect(input string name, input logic [1:0] off, input logic [31:0] exp);
        drive_cycle(1'b1, 1'b0, off, 32'h0, 1'b0, 8'h0);
        chk({name, "_ack"}, 32'(wb_ack_o), 32'd1);
        chk({name, "_dat"}, wb_dat_o, exp);
    endtask

    task automatic write_reg(input string name, input logic [1:0] off, input logic [31:0] d);
        drive_cycle(1'b1, 1'b1, off, d, 1'b0, 8'h0);
        chk({name, "_ack"}, 32'(wb_ack_o), 32'd1);
    endtask

    task automatic push_byte(input logic [7:0] b);
        drive_cycle(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, b);
        if (exp_q.size() < 16) exp_q.push_back(b);
    endtask

    task automatic pop_expect(input string name);
        logic [31:0] exp;
        if (exp_q.size() == 0) exp = 32'h8000_0000;
        else exp = {24'b0, exp_q.pop_front()};
        read_expect(name, 2'd0, exp);
    endtask

    initial begin
        logic [31:0] exp;

        // table: DATA/STATUS/CTRL basics, threshold irq, flush, clamping, err
        add_vec("rst_status", 1, 0, 1, 0, 0, 0, 1, 0, 0, 1, 32'h0001_0000);
        add_vec("rst_ctrl",   1, 0, 2, 0, 0, 0, 1, 0, 0, 1, 32'h0000_0100);
        add_vec("push41",     0, 0, 0, 0, 1, 8'h41, 0, 0, 0, 0, 0);
        add_vec("push42",     0, 0, 0, 0, 1, 8'h42, 0, 0, 0, 0, 0);
        add_vec("push43",     0, 0, 0, 0, 1, 8'h43, 0, 0, 0, 0, 0);
        add_vec("status3",    1, 0, 1, 0, 0, 0, 1, 0, 0, 1, 32'h0000_0003);
        add_vec("rd41",       1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h0000_0041);
        add_vec("rd42",       1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h0000_0042);
        add_vec("rd43",       1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h0000_0043);
        add_vec("rd_empty",   1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h8000_0000);
        add_vec("status0",    1, 0, 1, 0, 0, 0, 1, 0, 0, 1, 32'h0001_0000);
        add_vec("ctrl_w401",  1, 1, 2, 32'h0000_0401, 0, 0, 1, 0, 0, 0, 0);
        add_vec("ctrl_r401",  1, 0, 2, 0, 0, 0, 1, 0, 0, 1, 32'h0000_0401);
        add_vec("irq_push1",  0, 0, 0, 0, 1, 8'hA1, 0, 0, 0, 0, 0);
        add_vec("irq_push2",  0, 0, 0, 0, 1, 8'hA2, 0, 0, 0, 0, 0);
        add_vec("irq_push3",  0, 0, 0, 0, 1, 8'hA3, 0, 0, 0, 0, 0);
        add_vec("irq_push4",  0, 0, 0, 0, 1, 8'hA4, 0, 0, 1, 0, 0);
        add_vec("irq_pop",    1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h0000_00A1);
        add_vec("irq_status", 1, 0, 1, 0, 0, 0, 1, 0, 0, 1, 32'h0000_0003);
        add_vec("flush",      1, 1, 2, 32'h8000_0401, 0, 0, 1, 0, 0, 0, 0);
        add_vec("flush_stat", 1, 0, 1, 0, 0, 0, 1, 0, 0, 1, 32'h0001_0000);
        add_vec("flush_ctrl", 1, 0, 2, 0, 0, 0, 1, 0, 0, 1, 32'h0000_0401);
        add_vec("thr0_w",     1, 1, 2, 32'h0000_0000, 0, 0, 1, 0, 0, 0, 0);
        add_vec("thr0_r",     1, 0, 2, 0, 0, 0, 1, 0, 0, 1, 32'h0000_0100);
        add_vec("thr31_w",    1, 1, 2, 32'h0000_1F00, 0, 0, 1, 0, 0, 0, 0);
        add_vec("thr31_r",    1, 0, 2, 0, 0, 0, 1, 0, 0, 1, 32'h0000_1000);
        add_vec("thr1_w",     1, 1, 2, 32'h0000_0100, 0, 0, 1, 0, 0, 0, 0);
        add_vec("thr1_r",     1, 0, 2, 0, 0, 0, 1, 0, 0, 1, 32'h0000_0100);
        add_vec("fp_push1",   0, 0, 0, 0, 1, 8'hB1, 0, 0, 0, 0, 0);
        add_vec("fp_push2",   0, 0, 0, 0, 1, 8'hB2, 0, 0, 0, 0, 0);
        add_vec("fp_both",    1, 1, 2, 32'h8000_0100, 1, 8'hB3, 1, 0, 0, 0, 0);
        add_vec("fp_status",  1, 0, 1, 0, 0, 0, 1, 0, 0, 1, 32'h0001_0000);
        add_vec("fp_rd",      1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h8000_0000);
        add_vec("err_rd",     1, 0, 3, 0, 0, 0, 0, 1, 0, 1, 32'h0000_0000);
        add_vec("err_wr",     1, 1, 3, 32'hFFFF_FFFF, 0, 0, 0, 1, 0, 1, 32'h0000_0000);
        add_vec("err_ctrl",   1, 0, 2, 0, 0, 0, 1, 0, 0, 1, 32'h0000_0100);

        // reset phase
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_ack", 32'(wb_ack_o), 32'd0);
        chk("rst_err", 32'(wb_err_o), 32'd0);
        chk("rst_dat", wb_dat_o, 32'h0);
        chk("rst_irq", 32'(irq_o), 32'd0);
        chk("stall", 32'(wb_stall_o), 32'd0);
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;

        // table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            drive_cycle(vecs[i].bus, vecs[i].we, vecs[i].off, vecs[i].wdat,
                        vecs[i].push, vecs[i].pb);
            chk({vecs[i].name, "_ack"}, 32'(wb_ack_o), 32'(vecs[i].exp_ack));
            chk({vecs[i].name, "_err"}, 32'(wb_err_o), 32'(vecs[i].exp_err));
            chk({vecs[i].name, "_irq"}, 32'(irq_o), 32'(vecs[i].exp_irq));
            if (vecs[i].chk_dat) chk({vecs[i].name, "_dat"}, wb_dat_o, vecs[i].exp_dat);
        end

        // overflow: 17 pushes into 16 slots, clear, re-set, clear beats drop
        for (int i = 0; i < 17; i++) push_byte(8'(i));
        read_expect("ovf_status", 2'd1, 32'h0006_0010);
        write_reg("ovf_clear", 2'd1, 32'hFFFF_FFFF);
        read_expect("ovf_cleared", 2'd1, 32'h0002_0010);
        push_byte(8'h77);
        read_expect("ovf_again", 2'd1, 32'h0006_0010);
        drive_cycle(1'b1, 1'b1, 2'd1, 32'h0, 1'b1, 8'h78);
        chk("ovf_race_ack", 32'(wb_ack_o), 32'd1);
        read_expect("ovf_race", 2'd1, 32'h0002_0010);
        for (int i = 0; i < 16; i++) pop_expect("ovf_drain");
        read_expect("ovf_empty", 2'd1, 32'h0001_0000);

        // same-cycle push and DATA read on a full FIFO
        for (int i = 0; i < 16; i++) push_byte(8'h80 + 8'(i));
        exp = {24'b0, exp_q.pop_front()};
        drive_cycle(1'b1, 1'b0, 2'd0, 32'h0, 1'b1, 8'h5A);
        exp_q.push_back(8'h5A);
        chk("full_pp_ack", 32'(wb_ack_o), 32'd1);
        chk("full_pp_dat", wb_dat_o, exp);
        read_expect("full_pp_status", 2'd1, 32'h0002_0010);
        for (int i = 0; i < 16; i++) pop_expect("full_pp_drain");

        // same-cycle push and DATA read on an empty FIFO
        drive_cycle(1'b1, 1'b0, 2'd0, 32'h0, 1'b1, 8'h66);
        exp_q.push_back(8'h66);
        chk("empty_pp_dat", wb_dat_o, 32'h8000_0000);
        read_expect("empty_pp_status", 2'd1, 32'h0000_0001);
        pop_expect("empty_pp_drain");

        // pointer wrap: 40 push/pop pairs
        for (int i = 0; i < 40; i++) begin
            push_byte(8'(i * 5 + 1));
            pop_expect("wrap");
        end
        read_expect("wrap_status", 2'd1, 32'h0001_0000);

        // unmapped offset leaves state untouched
        push_byte(8'hC1);
        push_byte(8'hC2);
        push_byte(8'hC3);
        drive_cycle(1'b1, 1'b1, 2'd3, 32'h8000_0000, 1'b0, 8'h0);
        chk("err3_err", 32'(wb_err_o), 32'd1);
        chk("err3_ack", 32'(wb_ack_o), 32'd0);
        chk("err3_dat", wb_dat_o, 32'h0);
        read_expect("err3_status", 2'd1, 32'h0000_0003);

        // asynchronous reset with 5 bytes held and a transfer in flight
        push_byte(8'hC4);
        push_byte(8'hC5);
        write_reg("pre_rst_ctrl", 2'd2, 32'h0000_0301);
        chk("pre_rst_irq", 32'(irq_o), 32'd1);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_adr_i = BASE;
        reset_i  = 1'b0;
        #2;
        chk("arst_irq", 32'(irq_o), 32'd0);
        chk("arst_ack", 32'(wb_ack_o), 32'd0);
        @(posedge clk_i);
        #1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        chk("arst_noack", 32'(wb_ack_o), 32'd0);
        chk("arst_noerr", 32'(wb_err_o), 32'd0);
        chk("arst_dat", wb_dat_o, 32'h0);
        reset_i = 1'b1;
        exp_q.delete();
        @(posedge clk_i);
        #1;
        read_expect("post_rst_status", 2'd1, 32'h0001_0000);
        read_expect("post_rst_ctrl", 2'd2, 32'h0000_0100);
        chk("post_rst_irq", 32'(irq_o), 32'd0);
        pop_expect("post_rst_rd");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
